// File: rtl/bt_status_pkg.sv
// -----------------------------------------------------------------------------
// bt_status_pkg
// Shared constants, state encodings and the frame checksum for the Bluetooth
// status transmitter (bt_status_tx) and its byte serialiser (uart_tx_byte).
// -----------------------------------------------------------------------------
package bt_status_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_BYTES    = 6;
  localparam int         BITS_PER_BYTE  = 8;

  // Per-byte serialiser states (START/DATA/STOP live in uart_tx_byte)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Frame-level states: SEND covers the START/DATA/STOP sequence of all bytes
  typedef enum logic [1:0] {
    FR_IDLE = 2'd0,
    FR_SEND = 2'd1,
    FR_DONE = 2'd2
  } frame_state_e;

  // Modulo-256 sum of payload bytes B1..B4
  function automatic logic [7:0] frame_checksum(input logic [2:0]  song,
                                                input logic [15:0] vol,
                                                input logic        pause);
    return {5'b0, song} + vol[15:8] + vol[7:0] + {7'b0, pause};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Serialises one byte as 8N1 (start 0, 8 data bits LSB first, stop 1), each
// bit lasting BAUD_DIV clocks. A new byte may be accepted on the last cycle of
// the stop bit so consecutive bytes run with no idle gap.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_valid      byte available on i_data
//   i_data       byte to send
//   o_ready      byte accepted this cycle when i_valid is high
//   o_byte_done  one-cycle pulse on the final cycle of the stop bit
//   o_tx         registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_byte
  import bt_status_pkg::*;
#(
  parameter int BAUD_DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_byte_done,
  output logic       o_tx
);

  localparam int              CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]      BIT_LAST = 3'(BITS_PER_BYTE - 1);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_q, shift_n;
  logic             tx_q, tx_n;
  logic             baud_last;

  assign baud_last = (baud_cnt == CNT_LAST);
  assign o_tx      = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      tx_q     <= tx_n;
    end
  end

  // Data shift register carries no reset; it is always loaded before use
  always_ff @(posedge clk) begin
    shift_q <= shift_n;
  end

  always_comb begin
    state_n     = state;
    baud_cnt_n  = baud_last ? '0 : baud_cnt + 1'b1;
    bit_idx_n   = bit_idx;
    shift_n     = shift_q;
    o_ready     = 1'b0;
    o_byte_done = 1'b0;

    case (state)
      ST_IDLE: begin
        baud_cnt_n = '0;
        o_ready    = 1'b1;
        if (i_valid) begin
          state_n   = ST_START;
          shift_n   = i_data;
          bit_idx_n = '0;
        end
      end
      ST_START: begin
        if (baud_last) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (baud_last) begin
          shift_n = {1'b0, shift_q[7:1]};
          if (bit_idx == BIT_LAST) state_n = ST_STOP;
          else                     bit_idx_n = bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          o_byte_done = 1'b1;
          o_ready     = 1'b1;
          if (i_valid) begin
            // Chain straight into the next start bit: no idle gap
            state_n   = ST_START;
            shift_n   = i_data;
            bit_idx_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Line level is decoded from the next state so the output is a clean flop
    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: rtl/bt_status_tx.sv
// -----------------------------------------------------------------------------
// bt_status_tx
// Sends a 6-byte player status frame over UART to the Bluetooth module:
//   A5(HEADER) | {5'b0,song} | vol[15:8] | vol[7:0] | {7'b0,pause} | checksum
// Inputs are snapshotted when a frame starts; requests arriving while a frame
// is in flight collapse into one pending frame sent after the current one.
// Optional build macro BT_STATUS_TX_AUTO_REPORT_EN: any change of the status
// inputs also raises a send request.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_vol            volume {left[15:8], right[7:0]}
//   i_song_select    song index
//   i_pause          1 = paused
//   i_send           send request (pulse or level)
//   o_tx             UART line, idle high
//   o_busy           frame in flight
//   o_frame_done     one-cycle pulse after the final stop bit
// -----------------------------------------------------------------------------
module bt_status_tx
  import bt_status_pkg::*;
#(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         BAUD     = 9600,
  parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_vol,
  input  logic [2:0]  i_song_select,
  input  logic        i_pause,
  input  logic        i_send,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int         BAUD_DIV  = CLK_FREQ / BAUD;
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  frame_state_e fr_state, fr_state_n;
  logic [2:0]   byte_idx, byte_idx_n;
  logic [2:0]   next_idx;
  logic         pending, pending_n;
  logic         send_req;
  logic         go;
  logic [15:0]  vol_q;
  logic [2:0]   song_q;
  logic         pause_q;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic [7:0]   payload_byte;
  logic         tx_ready;
  logic         byte_done;

`ifdef BT_STATUS_TX_AUTO_REPORT_EN
  // Previous status resets to zero so a non-zero status after reset reports once
  logic [19:0] status_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_prev <= '0;
    else        status_prev <= {i_vol, i_song_select, i_pause};
  end

  assign send_req = i_send | (status_prev != {i_vol, i_song_select, i_pause});
`else
  assign send_req = i_send;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_state <= FR_IDLE;
      byte_idx <= '0;
      pending  <= 1'b0;
    end else begin
      fr_state <= fr_state_n;
      byte_idx <= byte_idx_n;
      pending  <= pending_n;
    end
  end

  // Snapshot the status only at the frame start; mid-frame changes are ignored
  always_ff @(posedge clk) begin
    if (go) begin
      vol_q   <= i_vol;
      song_q  <= i_song_select;
      pause_q <= i_pause;
    end
  end

  // Byte queued behind the one currently on the line
  assign next_idx = byte_idx + 3'd1;

  always_comb begin
    case (next_idx)
      3'd1:    payload_byte = {5'b0, song_q};
      3'd2:    payload_byte = vol_q[15:8];
      3'd3:    payload_byte = vol_q[7:0];
      3'd4:    payload_byte = {7'b0, pause_q};
      default: payload_byte = frame_checksum(song_q, vol_q, pause_q);
    endcase
  end

  always_comb begin
    fr_state_n   = fr_state;
    byte_idx_n   = byte_idx;
    pending_n    = pending | send_req;
    go           = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = HEADER;
    o_busy       = 1'b0;
    o_frame_done = 1'b0;

    case (fr_state)
      FR_IDLE: begin
        // The header is constant, so the first byte can launch on the same
        // edge that takes the snapshot
        go       = send_req | pending;
        tx_valid = go;
        if (go) begin
          fr_state_n = FR_SEND;
          pending_n  = 1'b0;
          byte_idx_n = '0;
        end
      end
      FR_SEND: begin
        o_busy   = 1'b1;
        tx_valid = (byte_idx != LAST_BYTE);
        tx_data  = payload_byte;
        if (tx_valid && tx_ready) byte_idx_n = next_idx;
        else if (byte_done)       fr_state_n = FR_DONE;
      end
      FR_DONE: begin
        o_frame_done = 1'b1;
        byte_idx_n   = '0;
        fr_state_n   = FR_IDLE;
      end
      default: fr_state_n = FR_IDLE;
    endcase
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (tx_valid),
    .i_data      (tx_data),
    .o_ready     (tx_ready),
    .o_byte_done (byte_done),
    .o_tx        (o_tx)
  );

endmodule

// File: tb/tb_bt_status_tx.sv
// -----------------------------------------------------------------------------
// tb_bt_status_tx
// Scoreboard bench for bt_status_tx at BAUD_DIV = 10. Stimulus pushes the
// hand-computed frame bytes into exp_q; a UART decoder monitor pops and compares
// every byte that appears on o_tx, and also tracks busy length and done pulses.
// -----------------------------------------------------------------------------
module tb_bt_status_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_vol = '0;
  logic [2:0]  i_song_select = '0;
  logic        i_pause = 1'b0;
  logic        i_send = 1'b0;
  logic        o_tx;
  logic        o_busy;
  logic        o_frame_done;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         busy_len = 0;
  int         busy_run = 0;
  int         d0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  bt_status_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .HEADER   (8'hA5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_vol         (i_vol),
    .i_song_select (i_song_select),
    .i_pause       (i_pause),
    .i_send        (i_send),
    .o_tx          (o_tx),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push6(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(b3); exp_q.push_back(b4); exp_q.push_back(b5);
  endtask

  task automatic wait_done(input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  task automatic quiet(input int n, input string name);
    bit bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (!o_tx || o_busy) bad = 1'b1;
    end
    check(name, bad, 1'b0);
  endtask

  // UART decoder and frame-activity monitor
  task automatic run_monitor();
    logic [7:0] sh;
    int         cnt;
    bit         act;
    sh  = '0;
    cnt = 0;
    act = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act      = 1'b0;
        busy_run = 0;
      end else begin
        if (o_busy) busy_run++;
        else if (busy_run != 0) begin
          busy_len = busy_run;
          busy_run = 0;
        end
        if (o_frame_done) begin
          done_cnt++;
          check("done_line_state", {o_busy, o_tx}, 2'b01);
        end
        if (!act) begin
          if (o_tx == 1'b0) begin
            act = 1'b1;
            cnt = 0;
          end
        end else begin
          cnt++;
          if (cnt == 5) check("start_bit", o_tx, 1'b0);
          else if (cnt >= 15 && cnt <= 85 && (cnt % 10) == 5) sh = {o_tx, sh[7:1]};
          else if (cnt == 95) begin
            check("stop_bit", o_tx, 1'b1);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_byte actual=%0h required=none", sh);
            end else begin
              check("frame_byte", sh, exp_q.pop_front());
            end
            act = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      run_monitor();
    join_none

    // Reset and idle line
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx",   o_tx,         1'b1);
    check("reset_busy", o_busy,       1'b0);
    check("reset_done", o_frame_done, 1'b0);
    quiet(200, "idle_quiet");

    // Basic frame
    d0 = done_cnt;
    @(negedge clk);
    i_vol = 16'h2030; i_song_select = 3'd5; i_pause = 1'b1; i_send = 1'b1;
    push6(8'hA5, 8'h05, 8'h20, 8'h30, 8'h01, 8'h56);
    @(negedge clk);
    i_send = 1'b0;
    check("basic_start_latency", {o_busy, o_tx}, 2'b10);
    wait_done(700, "basic_done");
    @(negedge clk);
    check("basic_done_single", o_frame_done, 1'b0);
    check("basic_busy_len", busy_len, 600);
    repeat (20) @(negedge clk);
    check("basic_done_count", done_cnt - d0, 1);
    check("basic_bytes_drained", exp_q.size(), 0);

    // Snapshot and collapsed pending frame
    d0 = done_cnt;
    @(negedge clk);
    i_vol = 16'h0000; i_song_select = 3'd3; i_pause = 1'b0; i_send = 1'b1;
    push6(8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h03);
    push6(8'hA5, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h01);
    @(negedge clk);
    i_send = 1'b0;
    for (int c = 2; c <= 500; c++) begin
      @(negedge clk);
      if (c == 100) i_vol = 16'hFFFF;
      i_send = (c == 150 || c == 300 || c == 450);
    end
    i_send = 1'b0;
    wait_done(200, "snap_first_done");
    @(negedge clk);
    check("pending_gap", {o_busy, o_tx}, 2'b01);
    @(negedge clk);
    check("pending_start", {o_busy, o_tx}, 2'b10);
    wait_done(700, "snap_second_done");
    repeat (300) @(negedge clk);
    check("pending_single", done_cnt - d0, 2);
    check("snap_bytes_drained", exp_q.size(), 0);

    // Checksum wrap
    @(negedge clk);
    i_vol = 16'hFFFF; i_song_select = 3'd7; i_pause = 1'b1; i_send = 1'b1;
    push6(8'hA5, 8'h07, 8'hFF, 8'hFF, 8'h01, 8'h06);
    @(negedge clk);
    i_send = 1'b0;
    wait_done(700, "wrap_done");
    @(negedge clk);
    check("wrap_busy_len", busy_len, 600);
    repeat (20) @(negedge clk);
    check("wrap_bytes_drained", exp_q.size(), 0);

    // Reset in the middle of a frame with a request pending
    d0 = done_cnt;
    @(negedge clk);
    i_vol = 16'h1234; i_song_select = 3'd1; i_pause = 1'b0; i_send = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    @(negedge clk);
    i_send = 1'b0;
    for (int c = 2; c <= 250; c++) begin
      @(negedge clk);
      i_send = (c == 100);
    end
    i_send = 1'b0;
    #1;
    rst_n = 1'b0;
    i_vol = '0; i_song_select = '0; i_pause = 1'b0;
    #1;
    check("abort_tx",   o_tx,         1'b1);
    check("abort_busy", o_busy,       1'b0);
    check("abort_done", o_frame_done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet(300, "abort_quiet");
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_bytes_drained", exp_q.size(), 0);

    // Status change without i_send
    d0 = done_cnt;
    @(negedge clk);
    i_song_select = 3'd2;
`ifdef BT_STATUS_TX_AUTO_REPORT_EN
    push6(8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02);
    @(negedge clk);
    check("auto_start_latency", {o_busy, o_tx}, 2'b10);
    wait_done(700, "auto_done");
    quiet(1000, "auto_static_quiet");
    check("auto_single", done_cnt - d0, 1);
`else
    quiet(700, "no_auto_quiet");
    check("no_auto_done", done_cnt - d0, 0);
`endif
    check("final_bytes_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
